bin2bcd_seq: RTL and testbench

- Sequential double-dabble converter. Turns the 16-bit result value from the pipelined core into packed BCD digits, so the display shows decimal instead of hex.
- Sits between the core's result output and the seven-segment driver. Runs on the same clock as the display logic.
- Uses a start/done handshake. Takes one shift-and-adjust step per cycle, so it costs no wide combinational adder chain.

---
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 tb/tb_bin2bcd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a start/done handshake.
// One add-3/shift step per clock keeps the combinational path to a single digit adder.
module bin2bcd_seq #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int DISP_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shift_bin;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               load_en;
    logic               step_en;
    logic               finish_en;
    logic               ovf_flag;

    // Each digit that is 5 or more gets +3 so the following shift carries into the next digit.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (cnt == CNT_W'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_en   = (state == IDLE) && start;
        step_en   = (state == CONVERT);
        finish_en = (state == FINISH);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_bin <= '0;
            scratch   <= '0;
            cnt       <= '0;
        end else if (load_en) begin
            shift_bin <= bin_in;
            scratch   <= '0;
            cnt       <= CNT_W'(WIDTH);
        end else if (step_en) begin
            {scratch, shift_bin} <= {add3_digits(scratch), shift_bin} << 1;
            cnt                  <= cnt - CNT_W'(1);
        end
    end

    // Without hidden digits there is nothing the display could miss.
    generate
        if (DISP_DIGITS >= DIGITS) begin : g_no_ovf
            assign ovf_flag = 1'b0;
        end else begin : g_ovf
            assign ovf_flag = |scratch[BCD_W-1:4*DISP_DIGITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= finish_en;
            if (finish_en) begin
                bcd_out  <= scratch;
                overflow <= ovf_flag;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a handshake model queues decimal expectations,
// a monitor checks every done pulse, latency, held outputs and busy each cycle.
module tb_bin2bcd_seq;

    localparam int W   = 16;
    localparam int D   = 5;
    localparam int DD  = 4;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   bin_in = '0;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd_out;
    logic           overflow;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D), .DISP_DIGITS(DD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    typedef struct {
        logic [4*D-1:0] bcd;
        logic           ovf;
        int             acc;
    } exp_t;

    exp_t           exp_q[$];
    int             cyc = 0;
    int             rem = 0;
    int             n_cmp = 0;
    int             n_fail = 0;
    bit             rst_edge = 1'b0;
    logic [4*D-1:0] last_bcd = '0;
    logic           last_ovf = 1'b0;

    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned    x;
        r = '0;
        x = v;
        for (int d = 0; d < D; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Handshake model: idle when nothing is outstanding; an accepted request occupies WIDTH+1 edges.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = rst;
            if (rst) begin
                exp_q.delete();
                rem = 0;
            end else if (rem == 0) begin
                if (start) begin
                    exp_q.push_back('{ref_bcd(int'(bin_in)), (int'(bin_in) >= 10**DD), cyc});
                    rem = LAT;
                end
            end else begin
                rem--;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_edge) begin
                last_bcd = '0;
                last_ovf = 1'b0;
                check("done_in_reset", 32'(done), 32'd0);
            end else if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", 32'(cyc - e.acc), 32'(LAT));
                    last_bcd = e.bcd;
                    last_ovf = e.ovf;
                end
            end else if (exp_q.size() > 0 && (cyc - exp_q[0].acc) > LAT) begin
                check("done_timeout", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            check("bcd_out", 32'(bcd_out), 32'(last_bcd));
            check("overflow", 32'(overflow), 32'(last_ovf));
            check("busy", 32'(busy), 32'(rem != 0));
            for (int d = 0; d < D; d++) begin
                if (bcd_out[4*d +: 4] > 4'd9) check("digit_range", 32'(bcd_out[4*d +: 4]), 32'd9);
            end
        end
    end

    task automatic pulse_start(input logic [W-1:0] v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && rem == 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int bcnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Zero conversion and the length of the busy window.
        pulse_start(16'd0);
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(bcnt), 32'(LAT));
        wait_idle();

        // Display boundary and full scale.
        pulse_start(16'd9999);
        wait_idle();
        pulse_start(16'd10000);
        wait_idle();
        pulse_start(16'hFFFF);
        wait_idle();
        check("ffff_bcd", 32'(last_bcd), 32'h65535);

        for (int n = 0; n < 1000; n++) begin
            pulse_start(W'($urandom));
            wait_idle();
        end

        // A start while busy must be ignored.
        pulse_start(16'd1234);
        repeat (3) @(negedge clk);
        pulse_start(16'd42);
        wait_idle();
        repeat (3) @(negedge clk);
        check("ignored_start", 32'(bcd_out), 32'h01234);

        // Start held high: back-to-back conversions, accepted in each done cycle.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd255;
        repeat (4 * (W + 2)) @(negedge clk);
        start  = 1'b0;
        wait_idle();

        // Reset in the middle of a conversion discards it.
        pulse_start(16'd500);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        repeat (25) @(negedge clk);
        pulse_start(16'd77);
        wait_idle();
        repeat (3) @(negedge clk);
        check("after_rst_bcd", 32'(bcd_out), 32'h00077);

        check("pending_at_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
